// File: rtl/bcd_calendar_counter_if.sv
// rtl/bcd_calendar_counter_if.sv - control, load and display signals of the BCD calendar counter
interface bcd_calendar_counter_if;
    logic       tick_en;
    logic       mode_12h;
    logic       load;
    logic [7:0] ld_sec;
    logic [7:0] ld_min;
    logic [7:0] ld_hour;
    logic [7:0] ld_day;
    logic [7:0] ld_month;
    logic [7:0] ld_year;
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hour;
    logic [7:0] day;
    logic [7:0] month;
    logic [7:0] year;
    logic       pm;
    logic [4:0] day_bin;
    logic       sec_tick;
    logic       min_tick;
    logic       hour_tick;
    logic       day_tick;
    logic       year_tick;
    logic       load_err;

    modport master (
        output tick_en, mode_12h, load,
        output ld_sec, ld_min, ld_hour, ld_day, ld_month, ld_year,
        input  sec, min, hour, day, month, year, pm, day_bin,
        input  sec_tick, min_tick, hour_tick, day_tick, year_tick, load_err
    );

    modport slave (
        input  tick_en, mode_12h, load,
        input  ld_sec, ld_min, ld_hour, ld_day, ld_month, ld_year,
        output sec, min, hour, day, month, year, pm, day_bin,
        output sec_tick, min_tick, hour_tick, day_tick, year_tick, load_err
    );
endinterface

// File: rtl/bcd_calendar_counter.sv
// rtl/bcd_calendar_counter.sv - BCD time-of-day and calendar counter with prescaler, load and 12h display
module bcd_calendar_counter #(
    parameter int unsigned PRESCALE   = 1,
    parameter logic [7:0]  RESET_YEAR = 8'h00,
    parameter bit          LEAP_EN    = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    bcd_calendar_counter_if.slave  bus
);
    localparam int unsigned    PW            = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESCALE_LAST = PW'(PRESCALE - 1);

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // year%4==0 straight from the digits: 10*t+u is a multiple of 4 iff (2t+u)%4==0
    function automatic logic leap_year(input logic [7:0] y);
        if (!LEAP_EN) return 1'b0;
        if (y[4]) return (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
        return (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
    endfunction

    function automatic logic [7:0] month_len(input logic [7:0] m, input logic [7:0] y);
        case (m)
            8'h02:                      return leap_year(y) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [4:0] bcd_to_bin(input logic [7:0] v);
        return 5'(v[7:4]) * 5'd10 + 5'(v[3:0]);
    endfunction

    logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [7:0]    day_q, day_d, month_q, month_d, year_q, year_d;
    logic [4:0]    day_bin_q, day_bin_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          adv_q, adv_d;
    logic          sec_tick_q, sec_tick_d, min_tick_q, min_tick_d;
    logic          hour_tick_q, hour_tick_d, day_tick_q, day_tick_d;
    logic          year_tick_q, year_tick_d, load_err_q, load_err_d;
    logic          ld_ok;
    logic [7:0]    hour_disp;

    always_comb begin
        ld_ok = bcd_ok(bus.ld_sec) && bcd_ok(bus.ld_min) && bcd_ok(bus.ld_hour) &&
                bcd_ok(bus.ld_day) && bcd_ok(bus.ld_month) && bcd_ok(bus.ld_year) &&
                (bus.ld_sec <= 8'h59) && (bus.ld_min <= 8'h59) && (bus.ld_hour <= 8'h23) &&
                (bus.ld_month >= 8'h01) && (bus.ld_month <= 8'h12) && (bus.ld_day >= 8'h01) &&
                (bus.ld_day <= month_len(bus.ld_month, bus.ld_year));
    end

    // adv_q holds the second advance earned by the last prescaler wrap
    always_comb begin
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        day_d       = day_q;
        month_d     = month_q;
        year_d      = year_q;
        presc_d     = presc_q;
        adv_d       = adv_q;
        sec_tick_d  = 1'b0;
        min_tick_d  = 1'b0;
        hour_tick_d = 1'b0;
        day_tick_d  = 1'b0;
        year_tick_d = 1'b0;
        load_err_d  = 1'b0;
        if (bus.load) begin
            if (ld_ok) begin
                sec_d   = bus.ld_sec;
                min_d   = bus.ld_min;
                hour_d  = bus.ld_hour;
                day_d   = bus.ld_day;
                month_d = bus.ld_month;
                year_d  = bus.ld_year;
                presc_d = '0;
                adv_d   = 1'b0;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            if (adv_q) begin
                adv_d      = 1'b0;
                sec_tick_d = 1'b1;
                if (sec_q == 8'h59) begin
                    sec_d      = 8'h00;
                    min_tick_d = 1'b1;
                    if (min_q == 8'h59) begin
                        min_d       = 8'h00;
                        hour_tick_d = 1'b1;
                        if (hour_q == 8'h23) begin
                            hour_d     = 8'h00;
                            day_tick_d = 1'b1;
                            if (day_q == month_len(month_q, year_q)) begin
                                day_d = 8'h01;
                                if (month_q == 8'h12) begin
                                    month_d     = 8'h01;
                                    year_tick_d = 1'b1;
                                    year_d      = (year_q == 8'h99) ? 8'h00 : bcd_inc(year_q);
                                end else begin
                                    month_d = bcd_inc(month_q);
                                end
                            end else begin
                                day_d = bcd_inc(day_q);
                            end
                        end else begin
                            hour_d = bcd_inc(hour_q);
                        end
                    end else begin
                        min_d = bcd_inc(min_q);
                    end
                end else begin
                    sec_d = bcd_inc(sec_q);
                end
            end
            if (bus.tick_en) begin
                if (presc_q == PRESCALE_LAST) begin
                    presc_d = '0;
                    adv_d   = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
        end
        day_bin_d = bcd_to_bin(day_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            hour_q      <= 8'h00;
            day_q       <= 8'h01;
            month_q     <= 8'h01;
            year_q      <= RESET_YEAR;
            day_bin_q   <= 5'd1;
            presc_q     <= '0;
            adv_q       <= 1'b0;
            sec_tick_q  <= 1'b0;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
            year_tick_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            day_bin_q   <= day_bin_d;
            presc_q     <= presc_d;
            adv_q       <= adv_d;
            sec_tick_q  <= sec_tick_d;
            min_tick_q  <= min_tick_d;
            hour_tick_q <= hour_tick_d;
            day_tick_q  <= day_tick_d;
            year_tick_q <= year_tick_d;
            load_err_q  <= load_err_d;
        end
    end

    // 12h view: 13-19 drop ten and two, 20-21 become 08-09, 22-23 become 10-11
    always_comb begin
        if (!bus.mode_12h)             hour_disp = hour_q;
        else if (hour_q == 8'h00)      hour_disp = 8'h12;
        else if (hour_q <= 8'h12)      hour_disp = hour_q;
        else if (hour_q[7:4] == 4'd1)  hour_disp = {4'd0, hour_q[3:0] - 4'd2};
        else if (hour_q[3:0] < 4'd2)   hour_disp = {4'd0, hour_q[3:0] + 4'd8};
        else                           hour_disp = {4'd1, hour_q[3:0] - 4'd2};
    end

    assign bus.sec       = sec_q;
    assign bus.min       = min_q;
    assign bus.hour      = hour_disp;
    assign bus.day       = day_q;
    assign bus.month     = month_q;
    assign bus.year      = year_q;
    assign bus.pm        = (hour_q >= 8'h12);
    assign bus.day_bin   = day_bin_q;
    assign bus.sec_tick  = sec_tick_q;
    assign bus.min_tick  = min_tick_q;
    assign bus.hour_tick = hour_tick_q;
    assign bus.day_tick  = day_tick_q;
    assign bus.year_tick = year_tick_q;
    assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_bcd_calendar_counter.sv
// tb/tb_bcd_calendar_counter.sv - self-checking bench for bcd_calendar_counter
module tb_bcd_calendar_counter;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset, reset4;

    bcd_calendar_counter_if i1();
    bcd_calendar_counter_if i4();

    bcd_calendar_counter #(.PRESCALE(1), .RESET_YEAR(8'h00), .LEAP_EN(1'b1))
        dut1 (.clock(clock), .reset(reset), .bus(i1));
    bcd_calendar_counter #(.PRESCALE(4), .RESET_YEAR(8'h24), .LEAP_EN(1'b1))
        dut4 (.clock(clock), .reset(reset4), .bus(i4));

    typedef struct { int s; int mi; int h; int d; int mo; int y; } tod_t;
    typedef struct {
        logic [7:0] s, mi, h, d, mo, y;
        int         nsec;
        logic [7:0] es, emi, eh, ed, emo, ey;
        logic       err;
        logic [4:0] stb;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction
    function automatic int bin(input logic [7:0] b);
        return 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction
    function automatic bit nib_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction
    function automatic int dim(input int mo, input int y);
        case (mo)
            2:           return (y % 4 == 0) ? 29 : 28;
            4, 6, 9, 11: return 30;
            default:     return 31;
        endcase
    endfunction
    function automatic int hdisp(input int h, input logic m12);
        if (!m12) return h;
        if (h == 0) return 12;
        return (h > 12) ? h - 12 : h;
    endfunction
    function automatic tod_t next_sec(input tod_t t);
        tod_t n = t;
        n.s++;
        if (n.s == 60) begin n.s = 0; n.mi++; end
        if (n.mi == 60) begin n.mi = 0; n.h++; end
        if (n.h == 24) begin n.h = 0; n.d++; end
        if (n.d > dim(n.mo, n.y)) begin n.d = 1; n.mo++; end
        if (n.mo == 13) begin n.mo = 1; n.y = (n.y + 1) % 100; end
        return n;
    endfunction
    function automatic bit ld_valid(input logic [7:0] s, mi, h, d, mo, y, output tod_t t);
        bit ok;
        ok = nib_ok(s) && nib_ok(mi) && nib_ok(h) && nib_ok(d) && nib_ok(mo) && nib_ok(y);
        t.s = bin(s); t.mi = bin(mi); t.h = bin(h); t.d = bin(d); t.mo = bin(mo); t.y = bin(y);
        return ok && t.s < 60 && t.mi < 60 && t.h < 24 && t.mo >= 1 && t.mo <= 12 &&
               t.d >= 1 && t.d <= dim(t.mo, t.y);
    endfunction
    function automatic vec_t mk(input logic [7:0] s, mi, h, d, mo, y, input int n,
                                input logic [7:0] es, emi, eh, ed, emo, ey,
                                input logic err, input logic [4:0] stb);
        vec_t v;
        v.s = s; v.mi = mi; v.h = h; v.d = d; v.mo = mo; v.y = y; v.nsec = n;
        v.es = es; v.emi = emi; v.eh = eh; v.ed = ed; v.emo = emo; v.ey = ey;
        v.err = err; v.stb = stb;
        return v;
    endfunction

    function automatic logic [4:0] stb1();
        return {i1.sec_tick, i1.min_tick, i1.hour_tick, i1.day_tick, i1.year_tick};
    endfunction

    task automatic load1(input logic [7:0] s, mi, h, d, mo, y);
        i1.ld_sec = s; i1.ld_min = mi; i1.ld_hour = h;
        i1.ld_day = d; i1.ld_month = mo; i1.ld_year = y;
        i1.load = 1'b1;
        cyc();
        i1.load = 1'b0;
    endtask

    task automatic pulse4();
        i4.tick_en = 1'b1;
        cyc();
        i4.tick_en = 1'b0;
    endtask

    task automatic chk_state1(input string tag, input tod_t t, input logic m12);
        chk({tag, ".sec"},     i1.sec,     bcd(t.s));
        chk({tag, ".min"},     i1.min,     bcd(t.mi));
        chk({tag, ".hour"},    i1.hour,    bcd(hdisp(t.h, m12)));
        chk({tag, ".day"},     i1.day,     bcd(t.d));
        chk({tag, ".month"},   i1.month,   bcd(t.mo));
        chk({tag, ".year"},    i1.year,    bcd(t.y));
        chk({tag, ".pm"},      i1.pm,      (t.h >= 12));
        chk({tag, ".day_bin"}, i1.day_bin, t.d);
    endtask

    vec_t tbl[15];
    tod_t mt, nt, lt;
    int   mcnt;
    bit   mpend, lv;
    logic m12, ld, tk, eerr;
    logic [4:0] estb;
    logic [7:0] ls, lmi, lh, ld_d, lmo, ly;

    initial begin
        {i1.tick_en, i1.mode_12h, i1.load} = '0;
        {i1.ld_sec, i1.ld_min, i1.ld_hour, i1.ld_day, i1.ld_month, i1.ld_year} = '0;
        {i4.tick_en, i4.mode_12h, i4.load} = '0;
        {i4.ld_sec, i4.ld_min, i4.ld_hour, i4.ld_day, i4.ld_month, i4.ld_year} = '0;
        reset = 1'b1;
        reset4 = 1'b1;

        tbl[0]  = mk(8'h59,8'h59,8'h23,8'h31,8'h12,8'h99, 1, 8'h00,8'h00,8'h00,8'h01,8'h01,8'h00, 0, 5'b11111);
        tbl[1]  = mk(8'h59,8'h59,8'h23,8'h28,8'h02,8'h24, 1, 8'h00,8'h00,8'h00,8'h29,8'h02,8'h24, 0, 5'b11110);
        tbl[2]  = mk(8'h59,8'h59,8'h23,8'h28,8'h02,8'h23, 1, 8'h00,8'h00,8'h00,8'h01,8'h03,8'h23, 0, 5'b11110);
        tbl[3]  = mk(8'h59,8'h59,8'h23,8'h29,8'h02,8'h24, 1, 8'h00,8'h00,8'h00,8'h01,8'h03,8'h24, 0, 5'b11110);
        tbl[4]  = mk(8'h10,8'h20,8'h15,8'h31,8'h04,8'h24, 0, 8'h00,8'h00,8'h00,8'h01,8'h03,8'h24, 1, 5'b00000);
        tbl[5]  = mk(8'h5A,8'h00,8'h00,8'h01,8'h01,8'h00, 0, 8'h00,8'h00,8'h00,8'h01,8'h03,8'h24, 1, 5'b00000);
        tbl[6]  = mk(8'h56,8'h34,8'h12,8'h30,8'h11,8'h20, 4, 8'h00,8'h35,8'h12,8'h30,8'h11,8'h20, 0, 5'b11000);
        tbl[7]  = mk(8'h59,8'h59,8'h23,8'h31,8'h12,8'h19, 1, 8'h00,8'h00,8'h00,8'h01,8'h01,8'h20, 0, 5'b11111);
        tbl[8]  = mk(8'h59,8'h59,8'h09,8'h30,8'h09,8'h05, 1, 8'h00,8'h00,8'h10,8'h30,8'h09,8'h05, 0, 5'b11100);
        tbl[9]  = mk(8'h59,8'h59,8'h23,8'h30,8'h04,8'h07, 1, 8'h00,8'h00,8'h00,8'h01,8'h05,8'h07, 0, 5'b11110);
        tbl[10] = mk(8'h00,8'h00,8'h24,8'h01,8'h01,8'h00, 0, 8'h00,8'h00,8'h00,8'h01,8'h05,8'h07, 1, 5'b00000);
        tbl[11] = mk(8'h00,8'h00,8'h00,8'h01,8'h13,8'h00, 0, 8'h00,8'h00,8'h00,8'h01,8'h05,8'h07, 1, 5'b00000);
        tbl[12] = mk(8'h00,8'h00,8'h00,8'h29,8'h02,8'h23, 0, 8'h00,8'h00,8'h00,8'h01,8'h05,8'h07, 1, 5'b00000);
        tbl[13] = mk(8'h59,8'h59,8'h23,8'h29,8'h02,8'h00, 1, 8'h00,8'h00,8'h00,8'h01,8'h03,8'h00, 0, 5'b11110);
        tbl[14] = mk(8'h00,8'h00,8'h00,8'h00,8'h01,8'h00, 0, 8'h00,8'h00,8'h00,8'h01,8'h03,8'h00, 1, 5'b00000);

        // reset state
        repeat (3) cyc();
        mt = '{s:0, mi:0, h:0, d:1, mo:1, y:0};
        chk_state1("reset", mt, 1'b0);
        chk("reset.strobes", stb1(), 5'b0);
        chk("reset.load_err", i1.load_err, 1'b0);
        i1.mode_12h = 1'b1;
        #1 chk("reset.hour12", i1.hour, 8'h12);
        i1.mode_12h = 1'b0;
        reset = 1'b0;
        cyc();

        // directed table: load, advance whole seconds, check strobes and final state
        foreach (tbl[i]) begin
            load1(tbl[i].s, tbl[i].mi, tbl[i].h, tbl[i].d, tbl[i].mo, tbl[i].y);
            chk($sformatf("tbl%0d.load_err", i), i1.load_err, tbl[i].err);
            if (tbl[i].nsec == 0) chk($sformatf("tbl%0d.no_strobe", i), stb1(), 5'b0);
            cyc();
            chk($sformatf("tbl%0d.load_err_clr", i), i1.load_err, 1'b0);
            for (int k = 0; k < tbl[i].nsec; k++) begin
                i1.tick_en = 1'b1;
                cyc();
                i1.tick_en = 1'b0;
                cyc();
                chk($sformatf("tbl%0d.sec_tick%0d", i, k), i1.sec_tick, 1'b1);
                if (k == tbl[i].nsec - 1) begin
                    chk($sformatf("tbl%0d.strobes", i), stb1(), tbl[i].stb);
                    cyc();
                    chk($sformatf("tbl%0d.strobes_clr", i), stb1(), 5'b0);
                end
            end
            chk($sformatf("tbl%0d.sec", i),   i1.sec,   tbl[i].es);
            chk($sformatf("tbl%0d.min", i),   i1.min,   tbl[i].emi);
            chk($sformatf("tbl%0d.hour", i),  i1.hour,  tbl[i].eh);
            chk($sformatf("tbl%0d.day", i),   i1.day,   tbl[i].ed);
            chk($sformatf("tbl%0d.month", i), i1.month, tbl[i].emo);
            chk($sformatf("tbl%0d.year", i),  i1.year,  tbl[i].ey);
            chk($sformatf("tbl%0d.day_bin", i), i1.day_bin, bin(tbl[i].ed));
        end

        // 12h display mapping and zero-latency mode change
        i1.mode_12h = 1'b1;
        load1(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00);
        chk("m12.h00", i1.hour, 8'h12); chk("m12.h00.pm", i1.pm, 1'b0);
        load1(8'h00, 8'h00, 8'h13, 8'h01, 8'h01, 8'h00);
        chk("m12.h13", i1.hour, 8'h01); chk("m12.h13.pm", i1.pm, 1'b1);
        load1(8'h00, 8'h00, 8'h12, 8'h01, 8'h01, 8'h00);
        chk("m12.h12", i1.hour, 8'h12); chk("m12.h12.pm", i1.pm, 1'b1);
        load1(8'h00, 8'h00, 8'h23, 8'h01, 8'h01, 8'h00);
        chk("m12.h23", i1.hour, 8'h11);
        i1.mode_12h = 1'b0;
        #1 chk("m12.toggle", i1.hour, 8'h23);
        i1.mode_12h = 1'b1;
        #1 chk("m12.toggle_back", i1.hour, 8'h11);
        i1.mode_12h = 1'b0;

        // rejected load swallows a simultaneous tick
        load1(8'h05, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00);
        i1.tick_en = 1'b1;
        load1(8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        i1.tick_en = 1'b0;
        chk("badld_tick.err", i1.load_err, 1'b1);
        cyc(); cyc();
        chk("badld_tick.sec", i1.sec, 8'h05);
        chk("badld_tick.sec_tick", i1.sec_tick, 1'b0);

        // reset while an advance is pending
        i1.tick_en = 1'b1;
        cyc();
        i1.tick_en = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst_mid.sec", i1.sec, 8'h00);
        chk("rst_mid.sec_tick", i1.sec_tick, 1'b0);
        cyc();
        chk("rst_mid.sec_after", i1.sec, 8'h00);
        chk("rst_mid.sec_tick_after", i1.sec_tick, 1'b0);

        // random stimulus against the reference model
        mt = '{s:0, mi:0, h:0, d:1, mo:1, y:0};
        mcnt = 0; mpend = 0; m12 = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            tk = ($urandom_range(0, 2) != 0);
            ld = !mpend && ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) m12 = ~m12;
            if (ld) begin
                lt.mo = $urandom_range(1, 12); lt.y = $urandom_range(0, 99);
                lt.d = dim(lt.mo, lt.y) - $urandom_range(0, 1);
                lt.h = $urandom_range(22, 23); lt.mi = $urandom_range(57, 59);
                lt.s = $urandom_range(55, 59);
                ls = bcd(lt.s); lmi = bcd(lt.mi); lh = bcd(lt.h);
                ld_d = bcd(lt.d); lmo = bcd(lt.mo); ly = bcd(lt.y);
                case ($urandom_range(0, 7))
                    0: ls   = 8'($urandom);
                    1: lh   = 8'($urandom);
                    2: ld_d = 8'($urandom_range(0, 63));
                    3: lmo  = 8'($urandom_range(0, 31));
                    4: ly   = 8'($urandom);
                    default: ;
                endcase
            end
            i1.tick_en = tk; i1.mode_12h = m12; i1.load = ld;
            i1.ld_sec = ls; i1.ld_min = lmi; i1.ld_hour = lh;
            i1.ld_day = ld_d; i1.ld_month = lmo; i1.ld_year = ly;
            estb = '0; eerr = 1'b0;
            if (ld) begin
                lv = ld_valid(ls, lmi, lh, ld_d, lmo, ly, lt);
                if (lv) begin mt = lt; mcnt = 0; mpend = 0; end
                else eerr = 1'b1;
            end else begin
                if (mpend) begin
                    nt = next_sec(mt);
                    estb = {1'b1, nt.mi != mt.mi, nt.h != mt.h, nt.d != mt.d, nt.y != mt.y};
                    mt = nt;
                    mpend = 0;
                end
                if (tk) begin
                    mcnt++;
                    if (mcnt == 1) begin mcnt = 0; mpend = 1; end
                end
            end
            cyc();
            i1.load = 1'b0; i1.tick_en = 1'b0;
            chk_state1($sformatf("rnd%0d", c), mt, m12);
            chk($sformatf("rnd%0d.strobes", c), stb1(), estb);
            chk($sformatf("rnd%0d.load_err", c), i1.load_err, eerr);
        end
        i1.mode_12h = 1'b0;

        // PRESCALE=4 instance
        reset4 = 1'b1;
        repeat (3) cyc();
        reset4 = 1'b0;
        chk("p4.reset_year", i4.year, 8'h24);
        chk("p4.reset_sec", i4.sec, 8'h00);
        for (int n = 1; n <= 5; n++) begin
            for (int p = 0; p < 4; p++) begin
                pulse4();
                chk($sformatf("p4.s%0d.p%0d.hold", n, p), i4.sec, bcd(n - 1));
                if (p == 3) begin
                    cyc();
                    chk($sformatf("p4.s%0d.adv", n), i4.sec, bcd(n));
                    chk($sformatf("p4.s%0d.tick", n), i4.sec_tick, 1'b1);
                end
                repeat ($urandom_range(0, 3)) cyc();
            end
        end
        pulse4(); pulse4();
        i4.ld_sec = 8'h10; i4.ld_min = 8'h00; i4.ld_hour = 8'h00;
        i4.ld_day = 8'h01; i4.ld_month = 8'h01; i4.ld_year = 8'h24;
        i4.load = 1'b1;
        cyc();
        i4.load = 1'b0;
        for (int p = 0; p < 3; p++) begin
            pulse4();
            cyc();
            chk($sformatf("p4.ldclr.p%0d", p), i4.sec, 8'h10);
        end
        pulse4(); cyc();
        chk("p4.ldclr.adv", i4.sec, 8'h11);
        pulse4(); pulse4();
        reset4 = 1'b1;
        cyc();
        reset4 = 1'b0;
        for (int p = 0; p < 3; p++) begin
            pulse4();
            cyc();
            chk($sformatf("p4.rstclr.p%0d", p), i4.sec, 8'h00);
        end
        pulse4(); cyc();
        chk("p4.rstclr.adv", i4.sec, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
